rr_burst_arbiter: RTL and testbench

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/rr_burst_arbiter.sv | 130 +++++++++++++
 tb/tb_rr_burst_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded grant tenures: the last owner gets the lowest
// priority, and a tenure ends on done, on the owner dropping req, or at MAX_BURST.
module rr_burst_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [7:0]           burst_cnt
);

   localparam int IW = $clog2(N);

   typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t        state_r, state_n_s;
   logic [IW-1:0] ptr_r, ptr_n_s;
   logic [N-1:0]  grant_r, grant_n_s;
   logic          grant_valid_r;
   logic [IW-1:0] grant_id_r, grant_id_n_s;
   logic [7:0]    burst_cnt_r, burst_cnt_n_s;

   logic [IW-1:0] base_s;
   logic [IW-1:0] win_id_s;
   logic          win_found_s;
   logic          release_s;

   // Search base: the stored pointer when idle, the current owner when releasing.
   always_comb begin
      if (state_r == OWNED) begin
         base_s = grant_id_r;
      end else begin
         base_s = ptr_r;
      end
   end

   // Find the first requester after base_s, wrapping; base_s itself is tried last.
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = {IW{1'b0}};
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(base_s) + k) % N;
         if (!win_found_s && req[idx]) begin
            win_found_s = 1'b1;
            win_id_s    = IW'(idx);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Any single cause or combination of causes yields one release.
   always_comb begin
      release_s = !req[grant_id_r] || done || (burst_cnt_r == 8'(MAX_BURST));
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n_s     = state_r;
      ptr_n_s       = ptr_r;
      grant_n_s     = grant_r;
      grant_id_n_s  = grant_id_r;
      burst_cnt_n_s = burst_cnt_r;
      case (state_r)
         IDLE: begin
            if (win_found_s) begin
               state_n_s     = OWNED;
               grant_n_s     = {{(N-1){1'b0}}, 1'b1} << win_id_s;
               grant_id_n_s  = win_id_s;
               burst_cnt_n_s = 8'd1;
            end else begin
               grant_n_s     = {N{1'b0}};
               burst_cnt_n_s = 8'd0;
            end
         end
         OWNED: begin
            if (release_s) begin
               ptr_n_s = grant_id_r;
               if (win_found_s) begin
                  grant_n_s     = {{(N-1){1'b0}}, 1'b1} << win_id_s;
                  grant_id_n_s  = win_id_s;
                  burst_cnt_n_s = 8'd1;
               end else begin
                  state_n_s     = IDLE;
                  grant_n_s     = {N{1'b0}};
                  burst_cnt_n_s = 8'd0;
               end
            end else begin
               burst_cnt_n_s = burst_cnt_r + 8'd1;
            end
         end
         default: begin
            state_n_s     = IDLE;
            grant_n_s     = {N{1'b0}};
            burst_cnt_n_s = 8'd0;
         end
      endcase
   end

   // State and output registers; reset clears grant without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         ptr_r         <= IW'(N - 1);
         grant_r       <= {N{1'b0}};
         grant_valid_r <= 1'b0;
         grant_id_r    <= {IW{1'b0}};
         burst_cnt_r   <= 8'd0;
      end else begin
         state_r       <= state_n_s;
         ptr_r         <= ptr_n_s;
         grant_r       <= grant_n_s;
         grant_valid_r <= |grant_n_s;
         grant_id_r    <= grant_id_n_s;
         burst_cnt_r   <= burst_cnt_n_s;
      end
   end

   assign grant       = grant_r;
   assign grant_valid = grant_valid_r;
   assign grant_id    = grant_id_r;
   assign burst_cnt   = burst_cnt_r;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed vector table for rr_burst_arbiter (N=4, MAX_BURST=4), plus hand-written
// reset-mid-tenure, all-request rotation and randomized property sequences.
module tb_rr_burst_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic [7:0] burst_cnt;

   int tests;
   int fails;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic       done;
      logic [3:0] grant;
      logic       gv;
      logic [1:0] id;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   rr_burst_arbiter #(.N(4), .MAX_BURST(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .burst_cnt   (burst_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic d,
                      input logic [3:0] g, input logic v, input logic [1:0] i,
                      input logic [7:0] c);
      vec_t e;
      e.rst_n = r; e.req = q; e.done = d; e.grant = g; e.gv = v; e.id = i; e.cnt = c;
      vecs.push_back(e);
   endtask

   initial begin
      logic [3:0] req_prev;
      logic [3:0] grant_prev;
      logic [7:0] cnt_prev;
      int         ones;

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;

      // reset state, req ignored while in reset
      add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
      add(1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
      // req=1010 held: 1 for four cycles, then 3, then 1 again, no gap
      add(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1);
      add(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2);
      add(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd3);
      add(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd4);
      add(1'b1, 4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd1);
      add(1'b1, 4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd2);
      add(1'b1, 4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd3);
      add(1'b1, 4'b1010, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd4);
      add(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1);
      // sole requester 0: re-granted every MAX_BURST, count restarts at 1
      add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd1);
      add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd2);
      add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd3);
      add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd4);
      add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd1);
      add(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd2);
      // owner 2, done in its second cycle with req=0111: search 3,0 -> 0
      add(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd1);
      add(1'b1, 4'b0111, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd2);
      add(1'b1, 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1);
      // owner 1 drops req together with done: single release to idle
      add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1);
      add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'd0);
      add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'd0);
      add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1);
      // non-owner req changes have no effect mid-tenure
      add(1'b1, 4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2);
      add(1'b1, 4'b1011, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd3);
      add(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd1);
      add(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd2);

      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n;
         req   = vecs[i].req;
         done  = vecs[i].done;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
         check($sformatf("vec%0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].gv));
         check($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].id));
         check($sformatf("vec%0d burst_cnt", i), 32'(burst_cnt), 32'(vecs[i].cnt));
      end

      // reset mid-tenure with grant=0100 must clear outputs before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("async_rst grant", 32'(grant), 32'h0);
      check("async_rst grant_valid", 32'(grant_valid), 32'h0);
      check("async_rst burst_cnt", 32'(burst_cnt), 32'h0);
      check("async_rst grant_id", 32'(grant_id), 32'h0);
      req = 4'b1111;
      done = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // all requesting: owners rotate 0,1,2,3 each for MAX_BURST cycles
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rot%0d grant_id", k), 32'(grant_id), 32'((k / 4) % 4));
         check($sformatf("rot%0d grant", k), 32'(grant), 32'(4'b0001 << ((k / 4) % 4)));
         check($sformatf("rot%0d burst_cnt", k), 32'(burst_cnt), 32'((k % 4) + 1));
      end

      // randomized traffic: structural properties of grant and burst_cnt
      grant_prev = grant;
      cnt_prev   = burst_cnt;
      for (int k = 0; k < 2000; k++) begin
         req  = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 3) == 0);
         req_prev = req;
         @(posedge clk);
         #1;
         ones = 0;
         for (int b = 0; b < 4; b++) begin
            if (grant[b]) ones++;
         end
         check($sformatf("rnd%0d onehot", k), 32'(ones <= 1), 32'h1);
         check($sformatf("rnd%0d valid", k), 32'(grant_valid), 32'(ones == 1));
         check($sformatf("rnd%0d cnt_idle", k), 32'(burst_cnt == 8'd0), 32'(ones == 0));
         check($sformatf("rnd%0d cnt_max", k), 32'(burst_cnt <= 8'd4), 32'h1);
         if (grant_valid) begin
            check($sformatf("rnd%0d id", k), 32'(grant), 32'(4'b0001 << grant_id));
            check($sformatf("rnd%0d req_at_grant", k), 32'((grant & req_prev) != 4'b0000), 32'h1);
            if (burst_cnt > 8'd1) begin
               check($sformatf("rnd%0d hold", k), 32'(grant), 32'(grant_prev));
               check($sformatf("rnd%0d incr", k), 32'(burst_cnt), 32'(cnt_prev + 8'd1));
            end
         end
         grant_prev = grant;
         cnt_prev   = burst_cnt;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
